// File: rtl/drums_pkg.sv
// drums_pkg: definitions shared by the bar sequencer and its step timer.
//   STEPS         - number of steps in one bar
//   LAST_STEP     - index of the final step of a bar
//   DEFAULT_DIV_W - default width of the step-period divider
//   seq_state_e   - playback state (IDLE / RUN / HOLD)
//   pattern_bit_sel() - maps a step index to its bit position in a bar word
package drums_pkg;

  localparam int STEPS         = 16;
  localparam int DEFAULT_DIV_W = 16;
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  // Bar words are written MSB-first: step 0 lives in bit 15, step 15 in bit 0.
  // For a 4-bit step index, 15 - step is simply the bitwise inverse.
  function automatic logic [3:0] pattern_bit_sel(input logic [3:0] step);
    return ~step;
  endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: down-counting divider that produces a one-cycle tick every
// max(i_div,1) enabled cycles.
//   clk     - clock
//   rst_n   - asynchronous active-low reset
//   i_load  - restart the period now (counter reloads from i_div)
//   i_en    - counting enabled; counter is held at zero while low
//   i_div   - cycles per tick, 0 behaves as 1; sampled only on load or tick
//   o_tick  - high for one cycle when the period elapses
module step_timer
  import drums_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_reload;

  // A divide of 0 is treated as 1, so both reload to zero and tick every cycle.
  always_comb begin
    w_reload = (i_div == '0) ? '0 : (i_div - DIV_W'(1));
  end

  assign o_tick = i_en & (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load || o_tick) begin
      r_cnt <= w_reload;
    end else if (i_en) begin
      r_cnt <= r_cnt - DIV_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/bar_sequencer.sv
// bar_sequencer: 16-step drum bar player with a one-deep shadow queue.
//   clk, rst_n  - clock, asynchronous active-low reset
//   bar_in      - bar pattern, bit 15 = step 0 ... bit 0 = step 15
//   bar_valid   - bar_in valid; accepted when bar_valid & bar_ready
//   bar_ready   - shadow register empty
//   tick_div    - clock cycles per step (0 treated as 1)
//   start, stop - level requests: begin/resume playback, stop at end of bar
//   hit         - strobe on a fired step whose pattern bit is 1
//   beat        - strobe on fired steps 0, 4, 8, 12
//   step_idx    - most recently fired step
//   bar_done    - strobe when step 15 fires
//   underrun    - strobe when a bar wraps with no queued bar (pattern replays)
//   running     - high in RUN or HOLD
// All strobes are registered: a step decided at a clock edge is visible in
// the following cycle, so the start-acceptance edge itself fires step 0.
module bar_sequencer
  import drums_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      bar_in,
  input  logic             bar_valid,
  output logic             bar_ready,
  input  logic [DIV_W-1:0] tick_div,
  input  logic             start,
  input  logic             stop,
  output logic             hit,
  output logic             beat,
  output logic [3:0]       step_idx,
  output logic             bar_done,
  output logic             underrun,
  output logic             running
);

  seq_state_e r_state;
  seq_state_e w_state_next;

  logic [15:0] r_active;
  logic [15:0] r_shadow;
  logic        r_shadow_full;
  logic [3:0]  r_step;        // next step to fire
  logic [3:0]  r_step_idx;
  logic        r_hit;
  logic        r_beat;
  logic        r_bar_done;
  logic        r_underrun;

  logic        w_tick;
  logic        w_timer_en;
  logic        w_start_fire;
  logic        w_resume;
  logic        w_halt;
  logic        w_fire_tick;
  logic        w_fire;
  logic        w_wrap;
  logic        w_xfer;
  logic        w_accept;
  logic [3:0]  w_fire_step;
  logic [15:0] w_pattern;
  logic        w_hit_next;
  logic        w_beat_next;
  logic        w_done_next;
  logic        w_underrun_next;

  assign w_timer_en = (r_state != ST_IDLE);

  step_timer #(
    .DIV_W (DIV_W)
  ) u_step_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start_fire),
    .i_en   (w_timer_en),
    .i_div  (tick_div),
    .o_tick (w_tick)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_fire) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt)      w_state_next = ST_IDLE;
        else if (stop)   w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_resume)    w_state_next = ST_RUN;
        else if (w_halt) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_start_fire = (r_state == ST_IDLE) & start & ~stop & r_shadow_full;
    w_resume     = (r_state == ST_HOLD) & start & ~stop;
    // r_step == 0 while running only happens right after step 15 fired, i.e.
    // at a bar boundary. A pending stop (RUN) or an unresumed HOLD ends
    // playback there, before step 0 of another bar can fire.
    w_halt       = (r_step == 4'd0) &
                   (((r_state == ST_RUN) & stop) |
                    ((r_state == ST_HOLD) & ~w_resume));
    w_fire_tick  = w_tick & ~w_halt;
    w_fire       = w_start_fire | w_fire_tick;
    w_fire_step  = w_start_fire ? 4'd0 : r_step;
    w_wrap       = w_fire_tick & (r_step == 4'd0);
    // The start edge and a bar wrap with something queued both move shadow
    // into active; the step fired on that edge already uses the new bar.
    w_xfer       = w_start_fire | (w_wrap & r_shadow_full);
    w_pattern    = w_xfer ? r_shadow : r_active;
    w_accept     = bar_valid & ~r_shadow_full;

    w_hit_next      = w_fire & w_pattern[pattern_bit_sel(w_fire_step)];
    w_beat_next     = w_fire & (w_fire_step[1:0] == 2'd0);
    w_done_next     = w_fire & (w_fire_step == LAST_STEP);
    w_underrun_next = w_wrap & ~r_shadow_full;
  end

  // Datapath and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active      <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
      r_step        <= 4'd0;
      r_step_idx    <= 4'd0;
      r_hit         <= 1'b0;
      r_beat        <= 1'b0;
      r_bar_done    <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_hit      <= w_hit_next;
      r_beat     <= w_beat_next;
      r_bar_done <= w_done_next;
      r_underrun <= w_underrun_next;
      if (w_fire) begin
        r_step     <= w_fire_step + 4'd1;
        r_step_idx <= w_fire_step;
      end
      if (w_xfer) begin
        r_active <= r_shadow;
      end
      if (w_accept) begin
        r_shadow <= bar_in;
      end
      // Accept needs the shadow empty and transfer needs it full, so the two
      // never collide.
      r_shadow_full <= (r_shadow_full & ~w_xfer) | w_accept;
    end
  end

  assign bar_ready = ~r_shadow_full;
  assign running   = (r_state != ST_IDLE);
  assign hit       = r_hit;
  assign beat      = r_beat;
  assign bar_done  = r_bar_done;
  assign underrun  = r_underrun;
  assign step_idx  = r_step_idx;

endmodule

// File: tb/tb_bar_sequencer.sv
// tb_bar_sequencer: scoreboard bench for bar_sequencer. Each scenario pushes
// the expected per-cycle output word {bar_ready, running, hit, beat,
// bar_done, underrun, step_idx} when it starts playback, then pops and
// compares one word per cycle. Cycle k counts clock edges after the
// start-acceptance edge (k = 1 is the first cycle after it).
module tb_bar_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bar_in = '0;
  logic        bar_valid = 1'b0;
  logic        bar_ready;
  logic [15:0] tick_div = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        hit;
  logic        beat;
  logic [3:0]  step_idx;
  logic        bar_done;
  logic        underrun;
  logic        running;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] sb[$];

  localparam logic [9:0] IDLE_WORD = 10'b10_0000_0000;

  bar_sequencer #(.DIV_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bar_in    (bar_in),
    .bar_valid (bar_valid),
    .bar_ready (bar_ready),
    .tick_div  (tick_div),
    .start     (start),
    .stop      (stop),
    .hit       (hit),
    .beat      (beat),
    .step_idx  (step_idx),
    .bar_done  (bar_done),
    .underrun  (underrun),
    .running   (running)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] observe();
    return {bar_ready, running, hit, beat, bar_done, underrun, step_idx};
  endfunction

  // Reference behaviour: p = cycles per step, b0 first bar, b1 bar queued
  // during cycle qc (when q1), last = final global step before playback ends.
  function automatic logic [9:0] model(input int k, input int p,
                                       input logic [15:0] b0, input logic [15:0] b1,
                                       input bit q1, input int qc, input int last);
    int g;
    int s;
    int n;
    logic [15:0] pat;
    logic h, bt, d, u, run, rdy;
    logic [3:0] idx;
    h = 1'b0; bt = 1'b0; d = 1'b0; u = 1'b0;
    g = (k - 1) / p;
    if (g > last) g = last;
    idx = 4'(g % 16);
    if (((k - 1) % p == 0) && ((k - 1) / p <= last)) begin
      s = g % 16;
      n = g / 16;
      pat = (n == 0 || !q1) ? b0 : b1;
      h  = pat[15 - s];
      bt = ((s % 4) == 0);
      d  = (s == 15);
      u  = (n >= 1) && (s == 0) && !(n == 1 && q1);
    end
    run = (k <= 1 + last * p);
    rdy = !(q1 && k > qc && k <= 16 * p);
    return {rdy, run, h, bt, d, u, idx};
  endfunction

  task automatic load_shadow(input logic [15:0] pat);
    @(negedge clk);
    bar_in = pat;
    bar_valid = 1'b1;
    @(negedge clk);
    bar_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = observe();
      n_checks++;
      if (obs !== IDLE_WORD) begin
        n_errors++;
        $display("FAIL reset_hold: got %b expected %b", obs, IDLE_WORD);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = observe();
      n_checks++;
      if (obs !== IDLE_WORD) begin
        n_errors++;
        $display("FAIL reset_release: got %b expected %b", obs, IDLE_WORD);
      end
    end
    start = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [9:0] obs, exp;
    load_shadow(16'h8888);
    n_checks++;
    if (bar_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_ready_low: got %b expected 0", bar_ready);
    end
    tick_div = 16'd4; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 64; k++) sb.push_back(model(k, 4, 16'h8888, 16'h0, 1'b0, 0, 15));
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL basic cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (k == 30) stop = 1'b1;
    end
    $display("test_basic done");
  endtask

  task automatic test_div0();
    logic [9:0] obs, exp;
    load_shadow(16'hFFFF);
    tick_div = 16'd0; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 18; k++) sb.push_back(model(k, 1, 16'hFFFF, 16'h0, 1'b0, 0, 15));
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL div0 cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (k == 3) stop = 1'b1;
    end
    $display("test_div0 done");
  endtask

  task automatic test_underrun();
    logic [9:0] obs, exp;
    load_shadow(16'hA5C3);
    tick_div = 16'd2; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 66; k++) sb.push_back(model(k, 2, 16'hA5C3, 16'h0, 1'b0, 0, 31));
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL underrun cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (k == 40) stop = 1'b1;
    end
    $display("test_underrun done");
  endtask

  task automatic test_queue();
    logic [9:0] obs, exp;
    load_shadow(16'hF0F0);
    tick_div = 16'd1; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 36; k++) sb.push_back(model(k, 1, 16'hF0F0, 16'h0F0F, 1'b1, 3, 31));
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL queue cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (k == 3) begin bar_in = 16'h0F0F; bar_valid = 1'b1; end
      if (k == 4) bar_valid = 1'b0;
      if (k == 20) stop = 1'b1;
    end
    $display("test_queue done");
  endtask

  task automatic test_stop_mid();
    logic [9:0] obs, exp;
    load_shadow(16'hB6D9);
    tick_div = 16'd3; start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      obs = observe();
      n_checks++;
      if (obs[9:4] !== 6'b000000) begin
        n_errors++;
        $display("FAIL start_stop_idle: got %b expected 000000", obs[9:4]);
      end
    end
    stop = 1'b0;
    for (int k = 1; k <= 50; k++) sb.push_back(model(k, 3, 16'hB6D9, 16'h0, 1'b0, 0, 15));
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL stop_mid cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (k == 16) stop = 1'b1;
    end
    $display("test_stop_mid done");
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs, exp;
    load_shadow(16'h1234);
    tick_div = 16'd2; stop = 1'b0; start = 1'b1;
    for (int k = 1; k <= 19; k++) sb.push_back(model(k, 2, 16'h1234, 16'h5A5A, 1'b1, 5, 31));
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      exp = sb.pop_front();
      obs = observe();
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", k, obs, exp);
      end
      if (k == 5) begin bar_in = 16'h5A5A; bar_valid = 1'b1; end
      if (k == 6) bar_valid = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1 obs = observe();
    n_checks++;
    if (obs !== IDLE_WORD) begin
      n_errors++;
      $display("FAIL reset_async: got %b expected %b", obs, IDLE_WORD);
    end
    start = 1'b1;
    @(negedge clk);
    obs = observe();
    n_checks++;
    if (obs !== IDLE_WORD) begin
      n_errors++;
      $display("FAIL reset_mid_hold: got %b expected %b", obs, IDLE_WORD);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs = observe();
      n_checks++;
      if (obs !== IDLE_WORD) begin
        n_errors++;
        $display("FAIL reset_mid_after %0d: got %b expected %b", i, obs, IDLE_WORD);
      end
    end
    start = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div0();
    test_underrun();
    test_queue();
    test_stop_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
